alu_8bit: RTL and testbench
===========================

Name: alu_8bit

Overview:
- Registered 8-bit combinational-operation ALU with a 4-bit opcode select, one result byte and a carry/flag bit.
- Sits as a leaf datapath block; the operands and opcode are sampled on a valid strobe, and the result is presented one clock later.
- Performs arithmetic, shift/rotate, bitwise logic and compare operations.

Parameters:
- WIDTH, 8, operand/result width. Fixed at 8; the opcode table below assumes 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid this cycle
- a  input  8  operand A (unsigned)
- b  input  8  operand B (unsigned)
- alu_sel  input  4  opcode
- alu_out  output  8  registered result
- carry_out  output  1  registered carry/flag
- out_valid  output  1  result valid, one-cycle pulse per accepted input

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low.
- Reset values: alu_out=8'h00, carry_out=0, out_valid=0. Reset asserted mid-operation discards the in-flight result.
- Timing: in_valid=1 at edge N captures the result at edge N, visible after edge N. Latency is 1 cycle and throughput is 1 per cycle. There is no backpressure.
- Idle behaviour: in_valid=0 at an edge gives out_valid=0 next cycle. alu_out and carry_out hold their previous values.
- Opcodes (all unsigned; results are the low 8 bits):
  - 0 ADD: a+b; carry = bit 8 of the 9-bit sum.
  - 1 SUB: a-b mod 256; carry = borrow (a<b).
  - 2 MUL: low byte of a*b; carry = OR of product bits 15:8.
  - 3 DIV: a/b (integer quotient). If b=0: out=8'hFF, carry=1. Otherwise carry=0.
  - 4 SHL: a<<1; carry = a[7].
  - 5 SHR: a>>1 (logical); carry = a[0].
  - 6 ROL: {a[6:0],a[7]}; carry=0.
  - 7 ROR: {a[0],a[7:1]}; carry=0.
  - 8 AND, 9 OR, 10 XOR, 11 NOR, 12 NAND, 13 XNOR: bitwise on a and b; carry=0.
  - 14 GT: out=8'h01 if a>b, else 8'h00; carry=0.
  - 15 EQ: out=8'h01 if a==b, else 8'h00; carry=0.
- Shifts and rotates use operand a only; b is ignored for these opcodes.
- No X propagation: every opcode value is defined, and unknown/default paths produce 0.

Decomposition:
- Shared package alu_pkg:
  - opcode enum (ALU_ADD..ALU_EQ, 4-bit).
  - WIDTH constant.
  - DIV0_RESULT = 8'hFF.
- One sub-module is natural: alu_8bit_comb, the purely combinational opcode decode and result/carry generation. The top module holds only the output and valid registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> alu_out=00, carry_out=0, out_valid=0 immediately; after release, the first in_valid produces a result one cycle later.
- Opcode sweep with a=0A, b=02, sel 0..15 -> outputs 0C,08,14,05,14,05,14,05,02,0A,08,F5,FD,F7,01,00, all with carry=0.
- Carry/borrow:
  - a=F6, b=0A, ADD -> 00, carry=1.
  - a=02, b=0A, SUB -> F8, carry=1.
  - a=80, b=00, SHL -> 00, carry=1.
  - a=10, b=10, MUL -> 00, carry=1.
- Divide by zero: a=0A, b=00, DIV -> FF, carry=1. Also a=FF, b=FF, EQ -> 01.
- Valid handling: back-to-back in_valid for 3 cycles -> 3 consecutive out_valid pulses with the matching results. A gap with in_valid=0 -> out_valid=0, and alu_out holds its last value.

Source files
------------

// File: rtl/alu_pkg.sv
// Purpose: shared opcode encoding and constants for the 8-bit ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int WIDTH = 8;

    localparam logic [WIDTH-1:0] DIV0_RESULT = 8'hFF;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_SHL  = 4'd4,
        ALU_SHR  = 4'd5,
        ALU_ROL  = 4'd6,
        ALU_ROR  = 4'd7,
        ALU_AND  = 4'd8,
        ALU_OR   = 4'd9,
        ALU_XOR  = 4'd10,
        ALU_NOR  = 4'd11,
        ALU_NAND = 4'd12,
        ALU_XNOR = 4'd13,
        ALU_GT   = 4'd14,
        ALU_EQ   = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_8bit_comb.sv
// Purpose: combinational opcode decode producing result byte and carry/flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module alu_8bit_comb
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_sel,
    output logic [WIDTH-1:0] o_res,
    output logic             o_carry
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    alu_op_e            w_op;

    // Wide arithmetic results; bit WIDTH of the difference is the borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    // Guard the divider so a zero divisor never reaches the '/' operator.
    assign w_quot = (i_b == '0) ? DIV0_RESULT : (i_a / i_b);
    assign w_op   = alu_op_e'(i_sel);

    // Select result and carry per opcode; anything undecoded yields zero.
    always_comb begin
        o_res   = '0;
        o_carry = 1'b0;
        case (w_op)
            ALU_ADD: begin
                o_res   = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
            end
            ALU_SUB: begin
                o_res   = w_diff[WIDTH-1:0];
                o_carry = w_diff[WIDTH];
            end
            ALU_MUL: begin
                o_res   = w_prod[WIDTH-1:0];
                o_carry = |w_prod[2*WIDTH-1:WIDTH];
            end
            ALU_DIV: begin
                o_res   = w_quot;
                o_carry = (i_b == '0);
            end
            ALU_SHL: begin
                o_res   = {i_a[WIDTH-2:0], 1'b0};
                o_carry = i_a[WIDTH-1];
            end
            ALU_SHR: begin
                o_res   = {1'b0, i_a[WIDTH-1:1]};
                o_carry = i_a[0];
            end
            ALU_ROL:  o_res = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
            ALU_ROR:  o_res = {i_a[0], i_a[WIDTH-1:1]};
            ALU_AND:  o_res = i_a & i_b;
            ALU_OR:   o_res = i_a | i_b;
            ALU_XOR:  o_res = i_a ^ i_b;
            ALU_NOR:  o_res = ~(i_a | i_b);
            ALU_NAND: o_res = ~(i_a & i_b);
            ALU_XNOR: o_res = ~(i_a ^ i_b);
            ALU_GT:   o_res = {{(WIDTH-1){1'b0}}, (i_a > i_b)};
            ALU_EQ:   o_res = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
            default: begin
                o_res   = '0;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_8bit.sv
// Purpose: registered 8-bit ALU; samples operands/opcode on in_valid.
// Latency: 1 cycle from accepted input to out_valid pulse.
// Backpressure: none; accepts one operation every cycle.
module alu_8bit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_carry_out;
    logic             r_out_valid;

    alu_8bit_comb u_comb (
        .i_a     (a),
        .i_b     (b),
        .i_sel   (alu_sel),
        .o_res   (w_res),
        .o_carry (w_carry)
    );

    // Capture result on accepted input; hold data otherwise, valid is a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out   <= '0;
            r_carry_out <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alu_out   <= w_res;
                r_carry_out <= w_carry;
            end
        end
    end

    assign alu_out   = r_alu_out;
    assign carry_out = r_carry_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_8bit.sv
module tb_alu_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       out_valid;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    string      name_q[$];
    logic [8:0] mon_exp;
    string      mon_name;

    always #5 clk = ~clk;

    alu_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got carry=%b out=%h, expected carry=%b out=%h",
                     name, got[8], got[7:0], expv[8], expv[7:0]);
        end
    endtask

    // Drive one operation and record the hand-computed response.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] sel,
                         input logic [7:0] eout, input logic ec);
        @(negedge clk);
        a        = ia;
        b        = ib;
        alu_sel  = sel;
        in_valid = 1'b1;
        exp_q.push_back({ec, eout});
        name_q.push_back($sformatf("op%0d_a%h_b%h", sel, ia, ib));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 out=%h, expected no result",
                         alu_out);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, {carry_out, alu_out}, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] sweep_exp [16];
    int         wait_cycles;

    initial begin
        sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        alu_sel  = 4'd0;
        #1;
        check("reset_out",   {1'b0, alu_out},   9'h000);
        check("reset_carry", {8'h00, carry_out}, 9'h000);
        check("reset_valid", {8'h00, out_valid}, 9'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Opcode sweep, back to back.
        for (int i = 0; i < 16; i++)
            issue(8'h0A, 8'h02, 4'(i), sweep_exp[i], 1'b0);

        // Carry / borrow / flag cases.
        issue(8'hF6, 8'h0A, 4'd0, 8'h00, 1'b1);
        issue(8'h02, 8'h0A, 4'd1, 8'hF8, 1'b1);
        issue(8'h80, 8'h00, 4'd4, 8'h00, 1'b1);
        issue(8'h10, 8'h10, 4'd2, 8'h00, 1'b1);
        issue(8'h0A, 8'h00, 4'd3, 8'hFF, 1'b1);
        issue(8'hFF, 8'hFF, 4'd15, 8'h01, 1'b0);
        issue(8'h81, 8'h55, 4'd5, 8'h40, 1'b1);
        idle();

        // Three back-to-back operations, then a gap.
        issue(8'h03, 8'h04, 4'd0, 8'h07, 1'b0);
        issue(8'h09, 8'h03, 4'd1, 8'h06, 1'b0);
        issue(8'hC3, 8'h00, 4'd6, 8'h87, 1'b0);
        idle();
        @(posedge clk); #1;
        check("gap_valid", {8'h00, out_valid}, 9'h000);
        check("gap_hold",  {carry_out, alu_out}, {1'b0, 8'h87});
        @(negedge clk);
        a = 8'hAA; b = 8'h55; alu_sel = 4'd9;
        @(posedge clk); #1;
        check("gap2_hold", {carry_out, alu_out}, {1'b0, 8'h87});

        // Reset mid-stream: in-flight operation must be discarded.
        issue(8'h0A, 8'h02, 4'd0, 8'h0C, 1'b0);
        @(negedge clk);
        a = 8'h55; b = 8'h55; alu_sel = 4'd15; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out",   {1'b0, alu_out},    9'h000);
        check("midrst_carry", {8'h00, carry_out}, 9'h000);
        check("midrst_valid", {8'h00, out_valid}, 9'h000);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h05, 8'h03, 4'd14, 8'h01, 1'b0);
        idle();

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drained: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
